// File: rtl/armleocpu_tlb_refill.sv
// TLB refill sequencer: accepts a miss, asks the page table walker for a translation,
// and writes the TLB or reports a fault, with a timeout on unresponsive walks.
module armleocpu_tlb_refill #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        miss_valid_i,
    input  logic [19:0] miss_vpn_i,
    output logic        miss_ready_o,
    input  logic        flush_i,

    output logic        ptw_resolve_request_o,
    output logic [31:0] ptw_resolve_virtual_address_o,
    input  logic        ptw_resolve_done_i,
    input  logic        ptw_resolve_pagefault_i,
    input  logic        ptw_resolve_accessfault_i,
    input  logic [21:0] ptw_resolve_physical_address_i,
    input  logic [7:0]  ptw_resolve_access_bits_i,

    output logic        tlb_write_o,
    output logic [19:0] tlb_write_vpn_o,
    output logic [21:0] tlb_write_ppn_o,
    output logic [7:0]  tlb_write_access_o,

    output logic        refill_done_o,
    output logic        refill_pagefault_o,
    output logic        refill_accessfault_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds the number of strobe-free WAIT cycles already elapsed.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;
    typedef enum logic [1:0] {ResOk, ResPf, ResAf} res_e;

    state_e          state_q, state_d;
    res_e            res_q, res_d;
    logic [19:0]     vpn_q, vpn_d;
    logic [21:0]     ppn_q, ppn_d;
    logic [7:0]      acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flush_pend_q, flush_pend_d;

    logic strobe;
    logic suppress;
    logic in_resp;

    assign strobe = ptw_resolve_done_i | ptw_resolve_pagefault_i | ptw_resolve_accessfault_i;

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        vpn_d        = vpn_q;
        ppn_d        = ppn_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            StIdle: begin
                flush_pend_d = 1'b0;
                if (miss_valid_i) begin
                    vpn_d   = miss_vpn_i;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (strobe) begin
                    ppn_d   = ptw_resolve_physical_address_i;
                    acc_d   = ptw_resolve_access_bits_i;
                    state_d = StRespond;
                    if (ptw_resolve_accessfault_i) begin
                        res_d = ResAf;
                    end else if (ptw_resolve_pagefault_i) begin
                        res_d = ResPf;
                    end else begin
                        res_d = ResOk;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    res_d   = ResAf;
                    state_d = StRespond;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRespond: begin
                flush_pend_d = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            res_q        <= ResOk;
            vpn_q        <= '0;
            ppn_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            vpn_q        <= vpn_d;
            ppn_q        <= ppn_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // A flush arriving in the RESPOND cycle itself must also cancel the write.
    assign suppress = flush_pend_q | flush_i;
    assign in_resp  = (state_q == StRespond);

    assign miss_ready_o                  = (state_q == StIdle);
    assign ptw_resolve_request_o         = (state_q == StWait);
    assign ptw_resolve_virtual_address_o = {vpn_q, 12'h000};

    assign tlb_write_o        = in_resp & (res_q == ResOk) & ~suppress;
    assign tlb_write_vpn_o    = vpn_q;
    assign tlb_write_ppn_o    = ppn_q;
    assign tlb_write_access_o = acc_q;

    assign refill_done_o        = in_resp;
    assign refill_pagefault_o   = in_resp & (res_q == ResPf) & ~suppress;
    assign refill_accessfault_o = in_resp & (res_q == ResAf) & ~suppress;

endmodule

// File: tb/tb_armleocpu_tlb_refill.sv
// Scoreboard bench for armleocpu_tlb_refill: directed refills push expected responses,
// a negedge monitor pops and compares them whenever the DUT reports completion.
module tb_armleocpu_tlb_refill;

    localparam int unsigned Timeout = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic [19:0] miss_vpn = '0;
    logic        miss_ready;
    logic        flush = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        ptw_done = 1'b0;
    logic        ptw_pf = 1'b0;
    logic        ptw_af = 1'b0;
    logic [21:0] ptw_ppn = '0;
    logic [7:0]  ptw_acc = '0;
    logic        tlb_write;
    logic [19:0] wr_vpn;
    logic [21:0] wr_ppn;
    logic [7:0]  wr_acc;
    logic        refill_done;
    logic        refill_pf;
    logic        refill_af;

    always #5 clk = ~clk;

    armleocpu_tlb_refill #(
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk_i                          (clk),
        .rst_i                          (rst),
        .miss_valid_i                   (miss_valid),
        .miss_vpn_i                     (miss_vpn),
        .miss_ready_o                   (miss_ready),
        .flush_i                        (flush),
        .ptw_resolve_request_o          (req),
        .ptw_resolve_virtual_address_o  (addr),
        .ptw_resolve_done_i             (ptw_done),
        .ptw_resolve_pagefault_i        (ptw_pf),
        .ptw_resolve_accessfault_i      (ptw_af),
        .ptw_resolve_physical_address_i (ptw_ppn),
        .ptw_resolve_access_bits_i      (ptw_acc),
        .tlb_write_o                    (tlb_write),
        .tlb_write_vpn_o                (wr_vpn),
        .tlb_write_ppn_o                (wr_ppn),
        .tlb_write_access_o             (wr_acc),
        .refill_done_o                  (refill_done),
        .refill_pagefault_o             (refill_pf),
        .refill_accessfault_o           (refill_af)
    );

    typedef struct {
        logic        wr;
        logic        pf;
        logic        af;
        logic [19:0] vpn;
        logic [21:0] ppn;
        logic [7:0]  acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (refill_done || tlb_write) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_response: got done=%0b write=%0b expected none",
                             refill_done, tlb_write);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done", 64'(refill_done), 64'(1'b1));
                    check("sb_write", 64'(tlb_write), 64'(e.wr));
                    check("sb_pagefault", 64'(refill_pf), 64'(e.pf));
                    check("sb_accessfault", 64'(refill_af), 64'(e.af));
                    if (e.wr) begin
                        check("sb_vpn", 64'(wr_vpn), 64'(e.vpn));
                        check("sb_ppn", 64'(wr_ppn), 64'(e.ppn));
                        check("sb_access", 64'(wr_acc), 64'(e.acc));
                    end
                end
            end
        end
    end

    // Called at the start of an IDLE cycle; returns at the start of the cycle after RESPOND.
    // n = strobe cycle (0: none, timeout), fl = flush cycle (0: IDLE, <0: none),
    // keep = leave miss_valid high so the next refill is accepted back-to-back.
    task automatic refill(input logic [19:0] vpn, input int n, input logic d, input logic pf,
                          input logic af, input logic [21:0] ppn, input logic [7:0] acc,
                          input int fl, input bit keep);
        exp_t e;
        int   last;
        bit   flushed;
        last      = (n == 0) ? int'(Timeout) : n;
        flushed   = (fl >= 1);
        e.af      = !flushed && (n == 0 || af);
        e.pf      = !flushed && n != 0 && !af && pf;
        e.wr      = !flushed && n != 0 && !af && !pf && d;
        e.vpn     = vpn;
        e.ppn     = ppn;
        e.acc     = acc;
        exp_q.push_back(e);

        miss_valid = 1'b1;
        miss_vpn   = vpn;
        if (fl == 0) flush = 1'b1;
        @(negedge clk);
        check("accept_ready", 64'(miss_ready), 64'(1'b1));
        tick();
        flush = 1'b0;
        if (!keep) miss_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c == n) begin
                ptw_done = d;
                ptw_pf   = pf;
                ptw_af   = af;
                ptw_ppn  = ppn;
                ptw_acc  = acc;
            end
            if (c == fl) flush = 1'b1;
            @(negedge clk);
            check("wait_request", 64'(req), 64'(1'b1));
            check("wait_address", 64'(addr), 64'({vpn, 12'h000}));
            check("wait_ready", 64'(miss_ready), 64'(1'b0));
            tick();
            ptw_done = 1'b0;
            ptw_pf   = 1'b0;
            ptw_af   = 1'b0;
            flush    = 1'b0;
        end
        @(negedge clk);
        check("respond_done", 64'(refill_done), 64'(1'b1));
        check("respond_request", 64'(req), 64'(1'b0));
        check("respond_ready", 64'(miss_ready), 64'(1'b0));
        tick();
    endtask

    initial begin
        tick();
        tick();
        @(negedge clk);
        check("rst_ready", 64'(miss_ready), 64'(1'b1));
        check("rst_request", 64'(req), 64'(1'b0));
        check("rst_address", 64'(addr), 64'(0));
        check("rst_write", 64'(tlb_write), 64'(1'b0));
        check("rst_done", 64'({refill_done, refill_pf, refill_af}), 64'(0));
        check("rst_entry", 64'({wr_vpn, wr_ppn, wr_acc}), 64'(0));
        tick();
        rst = 1'b0;

        // Basic success, then pagefault, pagefault+done, accessfault+pagefault.
        refill(20'hF00A1, 4, 1'b1, 1'b0, 1'b0, 22'h000401, 8'hCF, -1, 1'b0);
        refill(20'h00010, 2, 1'b0, 1'b1, 1'b0, 22'h0000AA, 8'h01, -1, 1'b0);
        refill(20'h00020, 3, 1'b1, 1'b1, 1'b0, 22'h0000BB, 8'h03, -1, 1'b0);
        refill(20'h00030, 1, 1'b0, 1'b1, 1'b1, 22'h0000CC, 8'h07, -1, 1'b0);
        // Timeout, then a strobe exactly in the timeout cycle.
        refill(20'h44444, 0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0, -1, 1'b0);
        refill(20'h55555, int'(Timeout), 1'b1, 1'b0, 1'b0, 22'h2ABCDE, 8'hC7, -1, 1'b0);
        // Flush in WAIT, then flush in IDLE (no effect).
        refill(20'h66666, 4, 1'b1, 1'b0, 1'b0, 22'h123456, 8'hFF, 2, 1'b0);
        refill(20'h77777, 2, 1'b1, 1'b0, 1'b0, 22'h3FFFFF, 8'h4B, 0, 1'b0);
        // Back-to-back with miss_valid held.
        refill(20'h12345, 2, 1'b1, 1'b0, 1'b0, 22'h011111, 8'h0F, -1, 1'b1);
        refill(20'hABCDE, 3, 1'b1, 1'b0, 1'b0, 22'h022222, 8'h1F, -1, 1'b0);

        // Reset during WAIT, followed by a late done strobe.
        miss_valid = 1'b1;
        miss_vpn   = 20'h3C3C3;
        @(negedge clk);
        tick();
        miss_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_request", 64'(req), 64'(1'b1));
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        ptw_done = 1'b1;
        ptw_ppn  = 22'h155555;
        ptw_acc  = 8'hCF;
        @(negedge clk);
        check("mid_rst_request", 64'(req), 64'(1'b0));
        check("mid_rst_address", 64'(addr), 64'(0));
        check("mid_rst_outputs", 64'({tlb_write, refill_done, refill_pf, refill_af}), 64'(0));
        check("mid_rst_ready", 64'(miss_ready), 64'(1'b1));
        tick();
        ptw_done = 1'b0;
        @(negedge clk);
        check("late_strobe_done", 64'(refill_done), 64'(1'b0));
        check("late_strobe_request", 64'(req), 64'(1'b0));
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
